// File: rtl/flash_prio_enc_pipe_if.sv
// flash_prio_enc_pipe_if: sample/result bundle for the pipelined flash priority encoder
//   master (producer): drives I_low, En_low, in_valid, cnt_clr; observes the results
//   slave  (encoder) : consumes the sample, drives Y, GS, EO_low, ovf, out_valid, bubble_cnt
interface flash_prio_enc_pipe_if #(
  parameter int N_IN  = 32,
  parameter int CNT_W = 16
);
  localparam int OUT_W = $clog2(N_IN);
  logic [N_IN-1:0]  I_low;
  logic             En_low;
  logic             in_valid;
  logic             cnt_clr;
  logic [OUT_W-1:0] Y;
  logic             GS;
  logic             EO_low;
  logic             ovf;
  logic             out_valid;
  logic [CNT_W-1:0] bubble_cnt;
  modport master (
    output I_low, En_low, in_valid, cnt_clr,
    input  Y, GS, EO_low, ovf, out_valid, bubble_cnt
  );
  modport slave (
    input  I_low, En_low, in_valid, cnt_clr,
    output Y, GS, EO_low, ovf, out_valid, bubble_cnt
  );
endinterface

// File: rtl/flash_prio_enc_pipe.sv
// flash_prio_enc_pipe: 2-stage active-low priority encoder for a flash ADC thermometer word
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of flash_prio_enc_pipe_if (sample in, Y/GS/EO_low/ovf/out_valid/bubble_cnt out)
//   FLASH_BUBBLE_CORR_EN : when defined, 3-input majority bubble correction and a saturating bubble counter
module flash_prio_enc_pipe #(
  parameter int N_IN  = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  flash_prio_enc_pipe_if.slave bus
);
  localparam int OUT_W = $clog2(N_IN);
  logic [N_IN-1:0]  a_q;
  logic [N_IN-1:0]  c;
  logic             en_low_q;
  logic             v1_q;
  logic [OUT_W-1:0] idx;
  logic             any;
  logic [OUT_W-1:0] y_q;
  logic             gs_q;
  logic             eo_q;
  logic             ovf_q;
  logic             ov_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      en_low_q <= 1'b0;
      v1_q     <= 1'b0;
    end else begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        a_q      <= ~bus.I_low;
        en_low_q <= bus.En_low;
      end
    end
  end
`ifdef FLASH_BUBBLE_CORR_EN
  // ext carries the virtual neighbours: a[N_IN] = 0 above, a[-1] = 1 below
  logic [N_IN+1:0]  ext;
  logic [CNT_W-1:0] cnt_q;
  assign ext = {1'b0, a_q, 1'b1};
  assign c = (ext[N_IN+1:2] & a_q) | (a_q & ext[N_IN-1:0]) | (ext[N_IN+1:2] & ext[N_IN-1:0]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (bus.cnt_clr)
      cnt_q <= '0;
    else if (v1_q && !en_low_q && c != a_q && cnt_q != '1)
      cnt_q <= cnt_q + 1'b1;
  end
  assign bus.bubble_cnt = cnt_q;
`else
  assign c = a_q;
  assign bus.bubble_cnt = '0;
`endif
  // ascending scan: the last set bit seen wins, giving the highest index
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (c[i]) begin
        idx = OUT_W'(i);
        any = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      gs_q  <= 1'b0;
      eo_q  <= 1'b1;
      ovf_q <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      ov_q <= v1_q;
      if (v1_q) begin
        y_q   <= en_low_q ? '0 : idx;
        gs_q  <= !en_low_q && any;
        eo_q  <= en_low_q || any;
        ovf_q <= !en_low_q && a_q[N_IN-1];
      end
    end
  end
  assign bus.Y         = y_q;
  assign bus.GS        = gs_q;
  assign bus.EO_low    = eo_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = ov_q;
endmodule

// File: tb/tb_flash_prio_enc_pipe.sv
// tb_flash_prio_enc_pipe: vector table, corner sequences and random scoreboard for two encoder instances
module tb_flash_prio_enc_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_low = '1;
  logic        en_low = 1'b0;
  logic        in_valid = 1'b0;
  logic        cnt_clr = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  always #5 clk = ~clk;
  flash_prio_enc_pipe_if #(.N_IN(32), .CNT_W(16)) bus_a ();
  flash_prio_enc_pipe_if #(.N_IN(16), .CNT_W(2))  bus_b ();
  assign bus_a.I_low    = i_low;
  assign bus_a.En_low   = en_low;
  assign bus_a.in_valid = in_valid;
  assign bus_a.cnt_clr  = cnt_clr;
  assign bus_b.I_low    = i_low[15:0];
  assign bus_b.En_low   = en_low;
  assign bus_b.in_valid = in_valid;
  assign bus_b.cnt_clr  = cnt_clr;
  flash_prio_enc_pipe #(.N_IN(32), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  flash_prio_enc_pipe #(.N_IN(16), .CNT_W(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  typedef struct packed {
    logic [7:0] y;
    logic       gs;
    logic       eo;
    logic       ovf;
    logic       bub;
  } res_t;
  typedef struct {
    int   due;
    res_t a;
    res_t b;
  } rec_t;
  typedef struct {
    logic [31:0] il;
    logic        en;
    int          y;
    logic        gs;
    logic        eo;
    logic        ovf;
  } vec_t;
  rec_t q[$];
  int   exp_cnt[2] = '{0, 0};
  int   cmax[2] = '{65535, 3};
  res_t last[2];
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // reference: majority vote by counting neighbours, then the highest set position
  function automatic res_t model(input logic [31:0] il, input logic en, input int n);
    logic [31:0] a;
    logic [31:0] c;
    int          hi;
    int          lo;
    res_t        r;
    a = ~il;
    c = a;
`ifdef FLASH_BUBBLE_CORR_EN
    for (int i = 0; i < n; i++) begin
      hi = (i == n - 1) ? 0 : int'(a[i+1]);
      lo = (i == 0) ? 1 : int'(a[i-1]);
      c[i] = (hi + int'(a[i]) + lo) >= 2;
    end
`endif
    r = '0;
    r.eo = 1'b1;
    if (!en) begin
      r.eo = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (c[i]) begin
          r.y = 8'(i);
          r.gs = 1'b1;
          r.eo = 1'b1;
        end
        if (c[i] != a[i]) r.bub = 1'b1;
      end
      r.ovf = a[n-1];
    end
    return r;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
    end else begin
      while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
      for (int d = 0; d < 2; d++) begin
        if (cnt_clr)
          exp_cnt[d] = 0;
        else if (q.size() > 0 && q[0].due == cyc + 1 && (d == 1 ? q[0].b.bub : q[0].a.bub) && exp_cnt[d] < cmax[d])
          exp_cnt[d]++;
      end
      if (in_valid) q.push_back('{due: cyc + 2, a: model(i_low, en_low, 32), b: model(i_low, en_low, 16)});
      cyc++;
    end
  end
  always @(negedge clk) begin
    logic v;
    res_t e;
    string nm;
    v = rst_n && q.size() > 0 && q[0].due == cyc;
    for (int d = 0; d < 2; d++) begin
      nm = d == 1 ? "b" : "a";
      e = v ? (d == 1 ? q[0].b : q[0].a) : last[d];
      if (!rst_n) e = '{y: 8'd0, gs: 1'b0, eo: 1'b1, ovf: 1'b0, bub: 1'b0};
      chk({nm, ".out_valid"}, int'(d == 1 ? bus_b.out_valid : bus_a.out_valid), int'(v));
      chk({nm, ".Y"}, d == 1 ? int'(bus_b.Y) : int'(bus_a.Y), int'(e.y));
      chk({nm, ".GS"}, int'(d == 1 ? bus_b.GS : bus_a.GS), int'(e.gs));
      chk({nm, ".EO_low"}, int'(d == 1 ? bus_b.EO_low : bus_a.EO_low), int'(e.eo));
      chk({nm, ".ovf"}, int'(d == 1 ? bus_b.ovf : bus_a.ovf), int'(e.ovf));
      chk({nm, ".bubble_cnt"}, d == 1 ? int'(bus_b.bubble_cnt) : int'(bus_a.bubble_cnt), exp_cnt[d]);
      last[d] = e;
    end
  end
  initial begin
    vec_t        tv[9];
    logic [15:0] s[3];
    int          ey[3];
    logic [31:0] a;
    int          k;
    tv[0] = '{32'hFFFF_0000, 1'b0, 15, 1'b1, 1'b1, 1'b0};
    tv[1] = '{32'hFFFF_FFFF, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tv[2] = '{32'h0000_0000, 1'b0, 31, 1'b1, 1'b1, 1'b1};
    tv[3] = '{32'h0000_0000, 1'b1, 0, 1'b0, 1'b1, 1'b0};
    tv[4] = '{32'h1234_5678, 1'b1, 0, 1'b0, 1'b1, 1'b0};
    tv[5] = '{32'hFFFF_FFFE, 1'b0, 0, 1'b1, 1'b1, 1'b0};
`ifdef FLASH_BUBBLE_CORR_EN
    tv[6] = '{32'hFFEF_0000, 1'b0, 15, 1'b1, 1'b1, 1'b0};
`else
    tv[6] = '{32'hFFEF_0000, 1'b0, 20, 1'b1, 1'b1, 1'b0};
`endif
    tv[7] = '{32'hFFFF_1000, 1'b0, 15, 1'b1, 1'b1, 1'b0};
    tv[8] = '{32'h8000_0000, 1'b0, 30, 1'b1, 1'b1, 1'b0};
    s  = '{16'hFFFE, 16'hFFF0, 16'h0000};
    ey = '{0, 3, 15};
    repeat (2) tick();
    chk("reset a.Y", int'(bus_a.Y), 0);
    chk("reset a.EO_low", int'(bus_a.EO_low), 1);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      i_low = tv[i].il;
      en_low = tv[i].en;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      en_low = 1'b0;
      chk($sformatf("vec%0d out_valid t+1", i), int'(bus_a.out_valid), 0);
      tick();
      chk($sformatf("vec%0d out_valid t+2", i), int'(bus_a.out_valid), 1);
      chk($sformatf("vec%0d Y", i), int'(bus_a.Y), tv[i].y);
      chk($sformatf("vec%0d GS", i), int'(bus_a.GS), int'(tv[i].gs));
      chk($sformatf("vec%0d EO_low", i), int'(bus_a.EO_low), int'(tv[i].eo));
      chk($sformatf("vec%0d ovf", i), int'(bus_a.ovf), int'(tv[i].ovf));
      tick();
      chk($sformatf("vec%0d out_valid t+3", i), int'(bus_a.out_valid), 0);
    end
`ifdef FLASH_BUBBLE_CORR_EN
    chk("table a.bubble_cnt", int'(bus_a.bubble_cnt), 2);
    chk("table b.bubble_cnt", int'(bus_b.bubble_cnt), 1);
`else
    chk("table a.bubble_cnt", int'(bus_a.bubble_cnt), 0);
    chk("table b.bubble_cnt", int'(bus_b.bubble_cnt), 0);
`endif
    for (int i = 0; i < 5; i++) begin
      in_valid = i < 3;
      if (i < 3) i_low = {16'hFFFF, s[i]};
      tick();
      if (i >= 1 && i <= 3) begin
        chk($sformatf("stream%0d b.out_valid", i - 1), int'(bus_b.out_valid), 1);
        chk($sformatf("stream%0d b.Y", i - 1), int'(bus_b.Y), ey[i-1]);
      end
    end
    in_valid = 1'b1;
    i_low = 32'hFFFF_FFEF;
    repeat (5) tick();
    in_valid = 1'b0;
    repeat (2) tick();
`ifdef FLASH_BUBBLE_CORR_EN
    chk("sat b.bubble_cnt", int'(bus_b.bubble_cnt), 3);
    chk("sat a.bubble_cnt", int'(bus_a.bubble_cnt), 7);
`else
    chk("sat b.bubble_cnt", int'(bus_b.bubble_cnt), 0);
    chk("sat a.bubble_cnt", int'(bus_a.bubble_cnt), 0);
`endif
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr b.bubble_cnt", int'(bus_b.bubble_cnt), 0);
    chk("clr a.bubble_cnt", int'(bus_a.bubble_cnt), 0);
    tick();
    chk("clr hold b.bubble_cnt", int'(bus_b.bubble_cnt), 0);
    in_valid = 1'b1;
    i_low = 32'hFFFF_0000;
    tick();
    i_low = 32'h0000_0000;
    tick();
    i_low = 32'h0000_0000;
    chk("pre-reset a.Y", int'(bus_a.Y), 15);
    rst_n = 1'b0;
    #1;
    chk("async reset a.out_valid", int'(bus_a.out_valid), 0);
    chk("async reset a.Y", int'(bus_a.Y), 0);
    chk("async reset a.GS", int'(bus_a.GS), 0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("post-reset no stale", int'(bus_a.out_valid), 0);
    end
    in_valid = 1'b1;
    i_low = 32'hFFFF_FF00;
    tick();
    in_valid = 1'b0;
    chk("post-reset t+1", int'(bus_a.out_valid), 0);
    tick();
    chk("post-reset t+2", int'(bus_a.out_valid), 1);
    chk("post-reset Y", int'(bus_a.Y), 7);
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(3) != 0;
      en_low = $urandom_range(4) == 0;
      cnt_clr = $urandom_range(40) == 0;
      k = $urandom_range(32);
      a = 32'((64'd1 << k) - 64'd1);
      if ($urandom_range(2) == 0) a[$urandom_range(31)] ^= 1'b1;
      i_low = ~a;
      tick();
    end
    in_valid = 1'b0;
    cnt_clr = 1'b0;
    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
